// File: rtl/ledoverride.sv
// ============================================================================
// Module   : ledoverride
// Brief    : Wishbone-controlled LED arbiter that passes the bouncer pattern
//            through, or shows a CPU-written pattern (held or timed).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ledoverride #(
  parameter int NLEDS           = 8,
  parameter int TIMERBITS       = 24,
  parameter int DEFAULT_TIMEOUT = 10000000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [1:0]       i_wb_addr,
  input  logic [31:0]      i_wb_data,
  input  logic [3:0]       i_wb_sel,
  output logic             o_wb_stall,
  output logic             o_wb_ack,
  output logic [31:0]      o_wb_data,
  input  logic [NLEDS-1:0] i_bounce,
  output logic [NLEDS-1:0] o_leds,
  output logic             o_override
);

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
    ST_TIMED = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NLEDS-1:0]       ledval_q, ledval_d;
  logic                   auto_q, auto_d;
  logic [TIMERBITS-1:0]   timeout_q, timeout_d;
  logic [TIMERBITS-1:0]   counter_q, counter_d;
  logic [NLEDS-1:0]       leds_q, leds_d;
  logic                   override_q, override_d;
  logic                   ack_q, ack_d;
  logic [31:0]            rdata_q, rdata_d;

  logic                   w_req;
  logic                   w_wr;
  logic [31:0]            w_mask;
  logic                   unused_ok;

  assign w_req  = i_wb_cyc & i_wb_stb;
  assign w_wr   = w_req & i_wb_we;
  assign w_mask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}},
                   {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};

  always_comb begin
    state_d   = state_q;
    ledval_d  = ledval_q;
    auto_d    = auto_q;
    timeout_d = timeout_q;
    counter_d = counter_q;

    if (state_q == ST_TIMED) begin
      if (counter_q == TIMERBITS'(1)) begin
        state_d   = ST_PASS;
        counter_d = '0;
      end else begin
        counter_d = counter_q - TIMERBITS'(1);
      end
    end

    // Bus writes are applied after expiry so that a write on the expiry edge wins.
    if (w_wr) begin
      case (i_wb_addr)
        2'd0: begin
          if (i_wb_sel[0]) begin
            auto_d = i_wb_data[0];
            if (i_wb_data[1])
              state_d = ST_PASS;
            else if ((state_q == ST_TIMED) && !i_wb_data[0])
              state_d = ST_HELD;
          end
        end
        2'd1: begin
          if (|i_wb_sel) begin
            ledval_d = (ledval_q & ~w_mask[NLEDS-1:0])
                     | (i_wb_data[NLEDS-1:0] & w_mask[NLEDS-1:0]);
            if (auto_q && (timeout_q != '0)) begin
              state_d   = ST_TIMED;
              counter_d = timeout_q;
            end else begin
              state_d   = ST_HELD;
            end
          end
        end
        2'd2: begin
          timeout_d = (timeout_q & ~w_mask[TIMERBITS-1:0])
                    | (i_wb_data[TIMERBITS-1:0] & w_mask[TIMERBITS-1:0]);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    leds_d     = (state_q == ST_PASS) ? i_bounce : ledval_q;
    override_d = (state_q != ST_PASS);
    ack_d      = w_req;
    rdata_d    = '0;
    if (w_req && !i_wb_we) begin
      case (i_wb_addr)
        2'd0: rdata_d[0]              = auto_q;
        2'd1: rdata_d[NLEDS-1:0]      = ledval_q;
        2'd2: rdata_d[TIMERBITS-1:0]  = timeout_q;
        default: begin
          rdata_d[31:30]     = state_q;
          rdata_d[NLEDS-1:0] = leds_q;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_PASS;
      ledval_q   <= '0;
      auto_q     <= 1'b1;
      timeout_q  <= TIMERBITS'(DEFAULT_TIMEOUT);
      counter_q  <= '0;
      leds_q     <= '0;
      override_q <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ledval_q   <= ledval_d;
      auto_q     <= auto_d;
      timeout_q  <= timeout_d;
      counter_q  <= counter_d;
      leds_q     <= leds_d;
      override_q <= override_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

  assign o_wb_stall = 1'b0;
  assign o_wb_ack   = ack_q;
  assign o_wb_data  = rdata_q;
  assign o_leds     = leds_q;
  assign o_override = override_q;

  // Sink for data/lane bits beyond the register widths.
  assign unused_ok = ^{i_wb_data, w_mask};

endmodule

`default_nettype wire

// File: tb/tb_ledoverride.sv
// ============================================================================
// Module   : tb_ledoverride
// Brief    : Directed self-checking bench for ledoverride with a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ledoverride;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic [7:0]  bounce = 8'h5A;
  logic        o_wb_stall, o_wb_ack, o_override;
  logic [31:0] o_wb_data;
  logic [7:0]  o_leds;

  int n_checks = 0;
  int n_errors = 0;

  ledoverride #(.NLEDS(8), .TIMERBITS(24), .DEFAULT_TIMEOUT(10000000)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdat), .i_wb_sel(sel),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
    .i_bounce(bounce), .o_leds(o_leds), .o_override(o_override)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0=PASS 1=TIMED 2=HELD; a timed override ends at an absolute cycle number.
  int          m_mode = 0;
  logic [7:0]  m_led = '0;
  logic        m_auto = 1'b1;
  logic [23:0] m_to = 24'd10000000;
  longint      m_cyc = 0, m_end = 0;
  logic [7:0]  exp_leds = '0;
  logic        exp_ovr = 1'b0, exp_ack = 1'b0, exp_rd = 1'b0;
  logic [31:0] exp_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_led = '0; m_auto = 1'b1; m_to = 24'd10000000;
      m_cyc = 0; m_end = 0;
      exp_leds = '0; exp_ovr = 1'b0; exp_ack = 1'b0; exp_rd = 1'b0; exp_rdata = '0;
    end else begin
      int old_mode;
      old_mode = m_mode;
      m_cyc++;
      exp_ack = cyc && stb;
      exp_rd  = cyc && stb && !we;
      case (addr)
        2'd0: exp_rdata = {31'd0, m_auto};
        2'd1: exp_rdata = {24'd0, m_led};
        2'd2: exp_rdata = {8'd0, m_to};
        default: exp_rdata = (m_mode * 32'h4000_0000) + {24'd0, exp_leds};
      endcase
      exp_leds = (m_mode == 0) ? bounce : m_led;
      exp_ovr  = (m_mode != 0);
      if (m_mode == 1 && m_cyc == m_end) m_mode = 0;
      if (cyc && stb && we) begin
        if (addr == 2'd0 && sel[0]) begin
          if (wdat[1]) m_mode = 0;
          else if (old_mode == 1 && !wdat[0]) m_mode = 2;
          m_auto = wdat[0];
        end else if (addr == 2'd1 && sel != 4'h0) begin
          if (sel[0]) m_led = wdat[7:0];
          if (m_auto && m_to != 0) begin
            m_mode = 1;
            m_end  = m_cyc + m_to;
          end else begin
            m_mode = 2;
          end
        end else if (addr == 2'd2) begin
          for (int b = 0; b < 3; b++)
            if (sel[b]) m_to[b*8 +: 8] = wdat[b*8 +: 8];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("leds", {24'd0, o_leds}, {24'd0, exp_leds});
      chk("override", {31'd0, o_override}, {31'd0, exp_ovr});
      chk("ack", {31'd0, o_wb_ack}, {31'd0, exp_ack});
      chk("stall", {31'd0, o_wb_stall}, 32'd0);
      if (exp_ack && exp_rd) chk("rdata", o_wb_data, exp_rdata);
    end
  end

  // Called at a falling edge; the request is accepted on the next rising edge.
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
    @(posedge clk);
    @(negedge clk);
    chk("ack_latency", {31'd0, o_wb_ack}, 32'd1);
    rd = o_wb_data;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    bus(1'b1, a, d, s, dummy);
  endtask

  task automatic rdchk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, a, 32'd0, 4'hF, v);
    chk(nm, v, exp);
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_leds", {24'd0, o_leds}, 32'd0);
    chk("rst_ovr", {31'd0, o_override}, 32'd0);
    chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("rst_data", o_wb_data, 32'd0);
    skip(2);
    rst_n = 1'b1;
    skip(2);
    chk("pass_5a", {24'd0, o_leds}, 32'h5A);
    rdchk("status_idle", 2'd3, 32'h0000_005A);
    rdchk("ctrl_rst", 2'd0, 32'd1);

    // Timed override of five cycles.
    wr(2'd2, 32'd5, 4'hF);
    wr(2'd1, 32'hC3, 4'hF);
    for (int k = 0; k < 5; k++) begin
      skip(1);
      chk("timed_c3", {24'd0, o_leds}, 32'hC3);
      chk("timed_ovr", {31'd0, o_override}, 32'd1);
    end
    skip(1);
    chk("timed_back", {24'd0, o_leds}, 32'h5A);
    chk("timed_ovr0", {31'd0, o_override}, 32'd0);

    // Held override, then release.
    wr(2'd0, 32'd0, 4'h1);
    wr(2'd1, 32'h81, 4'hF);
    skip(1000);
    chk("held_81", {24'd0, o_leds}, 32'h81);
    rdchk("status_held", 2'd3, 32'h8000_0081);
    wr(2'd0, 32'h2, 4'h1);
    chk("rel_lag", {24'd0, o_leds}, 32'h81);
    skip(1);
    chk("rel_pass", {24'd0, o_leds}, 32'h5A);

    // Zero timeout with auto-return never expires.
    bounce = 8'h3C;
    wr(2'd0, 32'h1, 4'h1);
    wr(2'd2, 32'd0, 4'hF);
    wr(2'd1, 32'hFF, 4'hF);
    skip(50);
    chk("zero_to", {24'd0, o_leds}, 32'hFF);
    rdchk("status_zero", 2'd3, 32'h8000_00FF);

    // Reload exactly on the expiry edge.
    wr(2'd2, 32'd4, 4'hF);
    wr(2'd1, 32'h11, 4'hF);
    skip(3);
    wr(2'd1, 32'h22, 4'hF);
    for (int k = 0; k < 4; k++) begin
      skip(1);
      chk("reload_22", {24'd0, o_leds}, 32'h22);
    end
    skip(1);
    chk("reload_back", {24'd0, o_leds}, 32'h3C);

    // Lane masking, ignored writes, clearing auto-return mid-count.
    wr(2'd1, 32'hAA, 4'h2);
    wr(2'd1, 32'h99, 4'h0);
    wr(2'd3, 32'hFFFF_FFFF, 4'hF);
    wr(2'd0, 32'h0, 4'h1);
    rdchk("ledval_mask", 2'd1, 32'h22);
    rdchk("status_auto0", 2'd3, 32'h8000_0022);
    wr(2'd0, 32'h3, 4'h1);
    wr(2'd2, 32'h00AB_CDEF, 4'h5);
    rdchk("timeout_mask", 2'd2, 32'h00AB_0004 | 32'h0000_00EF);

    // Asynchronous reset during a timed override.
    wr(2'd1, 32'h3C, 4'hF);
    skip(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_leds", {24'd0, o_leds}, 32'd0);
    chk("arst_ovr", {31'd0, o_override}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdchk("arst_timeout", 2'd2, 32'h0098_9680);
    rdchk("arst_ctrl", 2'd0, 32'd1);
    chk("arst_pass", {24'd0, o_leds}, 32'h3C);

    skip(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
